// File: rtl/periph_xbar_pkg.sv
// Shared types and helpers for the peripheral crossbar.
package periph_xbar_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} xbar_state_e;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADA_CCE5;

   // Index width that never collapses to zero bits for single-entry vectors.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/periph_xbar_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module periph_xbar_rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [IW-1:0] j;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((32'(ptr_i) + unsigned'(k)) % N);
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = j;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_xbar.sv
// NB_MASTER x NB_SLAVE req/gnt/rvalid crossbar with per-port round-robin arbiters
// and an internal error responder for unmapped addresses.
//
// state | meaning
// IDLE  | port free, arbitrating among eligible masters
// WAIT  | one transaction outstanding, waiting for its rvalid
module periph_xbar
   import periph_xbar_pkg::*;
#(
   parameter int unsigned NB_MASTER  = 3,
   parameter int unsigned NB_SLAVE   = 3,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
      {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
   parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
      {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF},
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NB_MASTER-1:0]                m_req_i,
   input  logic [NB_MASTER*ADDR_WIDTH-1:0]     m_addr_i,
   input  logic [NB_MASTER-1:0]                m_we_i,
   input  logic [NB_MASTER*(DATA_WIDTH/8)-1:0] m_be_i,
   input  logic [NB_MASTER*DATA_WIDTH-1:0]     m_wdata_i,
   output logic [NB_MASTER-1:0]                m_gnt_o,
   output logic [NB_MASTER-1:0]                m_rvalid_o,
   output logic [NB_MASTER*DATA_WIDTH-1:0]     m_rdata_o,
   output logic [NB_MASTER-1:0]                m_err_o,
   output logic [NB_SLAVE-1:0]                 s_req_o,
   output logic [NB_SLAVE*ADDR_WIDTH-1:0]      s_addr_o,
   output logic [NB_SLAVE-1:0]                 s_we_o,
   output logic [NB_SLAVE*(DATA_WIDTH/8)-1:0]  s_be_o,
   output logic [NB_SLAVE*DATA_WIDTH-1:0]      s_wdata_o,
   input  logic [NB_SLAVE-1:0]                 s_gnt_i,
   input  logic [NB_SLAVE-1:0]                 s_rvalid_i,
   input  logic [NB_SLAVE*DATA_WIDTH-1:0]      s_rdata_i
);

   localparam int unsigned BW = DATA_WIDTH / 8;
   localparam int unsigned NP = NB_SLAVE + 1;
   localparam int unsigned MW = clog2_min1(NB_MASTER);
   localparam int unsigned TW = clog2_min1(NP);

   logic [NB_MASTER-1:0][TW-1:0] tgt;
   logic [NB_MASTER-1:0]         pend_q, pend_d;
   logic [NB_MASTER-1:0]         gnt_oh_a [NP];
   logic                         rvalid_a [NP];
   logic [MW-1:0]                owner_a  [NP];
   logic [DATA_WIDTH-1:0]        rdata_a  [NP];

   // Lowest matching slave wins; no match selects the error port (index NB_SLAVE).
   always_comb begin
      for (int m = 0; m < NB_MASTER; m++) begin
         tgt[m] = TW'(NB_SLAVE);
         for (int s = NB_SLAVE - 1; s >= 0; s--) begin
            if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH] &&
                m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH])
               tgt[m] = TW'(s);
         end
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_port
      xbar_state_e          state_q, state_d;
      logic [MW-1:0]        owner_q, owner_d, ptr_q, ptr_d, win_idx;
      logic [NB_MASTER-1:0] elig, win_oh;
      logic                 win_valid, port_req, port_gnt, port_rvalid, dn_gnt, dn_rvalid;

      always_comb begin
         elig = '0;
         for (int m = 0; m < NB_MASTER; m++)
            elig[m] = m_req_i[m] & ~pend_q[m] & (tgt[m] == TW'(p));
      end

      periph_xbar_rr_arbiter #(.N(NB_MASTER), .IW(MW)) u_arb (
         .req_i   (elig),
         .ptr_i   (ptr_q),
         .gnt_o   (win_oh),
         .idx_o   (win_idx),
         .valid_o (win_valid)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
         end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
         end
      end

      always_comb begin
         state_d = state_q;
         owner_d = owner_q;
         ptr_d   = ptr_q;
         case (state_q)
            IDLE: if (port_gnt) begin
               state_d = WAIT;
               owner_d = win_idx;
               ptr_d   = (win_idx == MW'(NB_MASTER - 1)) ? '0 : win_idx + 1'b1;
            end
            WAIT: if (port_rvalid) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      always_comb begin
         port_req    = !rst && (state_q == IDLE) && win_valid;
         port_gnt    = port_req && dn_gnt;
         port_rvalid = !rst && (state_q == WAIT) && dn_rvalid;
      end

      if (p < NB_SLAVE) begin : g_slv
         assign dn_gnt     = s_gnt_i[p];
         assign dn_rvalid  = s_rvalid_i[p];
         assign rdata_a[p] = s_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
         assign s_req_o[p] = port_req;
         assign s_we_o[p]  = port_req ? m_we_i[win_idx] : 1'b0;
         assign s_addr_o[p*ADDR_WIDTH +: ADDR_WIDTH] =
            port_req ? m_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
         assign s_be_o[p*BW +: BW] = port_req ? m_be_i[win_idx*BW +: BW] : '0;
         assign s_wdata_o[p*DATA_WIDTH +: DATA_WIDTH] =
            port_req ? m_wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_err
         // Error responder accepts immediately and answers on the following cycle.
         assign dn_gnt     = 1'b1;
         assign dn_rvalid  = 1'b1;
         assign rdata_a[p] = ERR_RDATA;
      end

      assign gnt_oh_a[p] = port_gnt ? win_oh : '0;
      assign rvalid_a[p] = port_rvalid;
      assign owner_a[p]  = owner_q;
   end

   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      m_err_o    = '0;
      m_rdata_o  = '0;
      for (int p = 0; p < NP; p++) begin
         m_gnt_o = m_gnt_o | gnt_oh_a[p];
         if (rvalid_a[p]) begin
            m_rvalid_o[owner_a[p]] = 1'b1;
            m_err_o[owner_a[p]]    = (p == NP - 1);
            m_rdata_o[owner_a[p]*DATA_WIDTH +: DATA_WIDTH] = rdata_a[p];
         end
      end
   end

   assign pend_d = (pend_q | m_gnt_o) & ~m_rvalid_o;

   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

endmodule

// File: tb/tb_periph_xbar.sv
// Directed bench for periph_xbar: stimulus pushes expected responses, a monitor pops them on m_rvalid_o.
module tb_periph_xbar;

   typedef struct {
      int          m;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  m_req, m_we, m_gnt, m_rvalid, m_err;
   logic [2:0]  s_req, s_we, s_gnt, s_rvalid;
   logic [95:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata, s_rdata;
   logic [11:0] m_be, s_be;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t expq[$];
   int   ord [4] = '{0, 1, 2, 0};
   logic [31:0] rr_dat [4] = '{32'hA001, 32'hA002, 32'hA003, 32'hA004};

   always #5 clk = ~clk;

   periph_xbar dut (
      .clk        (clk),
      .rst        (rst),
      .m_req_i    (m_req),
      .m_addr_i   (m_addr),
      .m_we_i     (m_we),
      .m_be_i     (m_be),
      .m_wdata_i  (m_wdata),
      .m_gnt_o    (m_gnt),
      .m_rvalid_o (m_rvalid),
      .m_rdata_o  (m_rdata),
      .m_err_o    (m_err),
      .s_req_o    (s_req),
      .s_addr_o   (s_addr),
      .s_we_o     (s_we),
      .s_be_o     (s_be),
      .s_wdata_o  (s_wdata),
      .s_gnt_i    (s_gnt),
      .s_rvalid_i (s_rvalid),
      .s_rdata_i  (s_rdata)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int m, input logic [31:0] d, input logic e);
      exp_t x;
      x.m = m; x.data = d; x.err = e;
      expq.push_back(x);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            for (int m = 0; m < 3; m++) begin
               if (m_rvalid[m]) begin
                  if (expq.size() == 0) begin
                     chk($sformatf("spurious_rvalid_m%0d", m), m_rvalid[m], 1'b0);
                  end else begin
                     x = expq.pop_front();
                     chk("rsp_master", m, x.m);
                     chk("rsp_rdata", m_rdata[m*32 +: 32], x.data);
                     chk("rsp_err", m_err[m], x.err);
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      rst = 1'b1;
      m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
      s_gnt = 3'b111; s_rvalid = '0; s_rdata = '0;

      // Reset state, with a request already pending on M0
      step(); m_req = 3'b001; m_addr[31:0] = 32'h0;
      #1 chk("rst_gnt", m_gnt, 3'b000);
      chk("rst_sreq", s_req, 3'b000);
      chk("rst_rvalid", m_rvalid, 3'b000);
      chk("rst_saddr", s_addr, 96'h0);
      step();
      step(); rst = 1'b0; m_req = '0;

      // 1: read slave 1, two-cycle response
      step(); m_req = 3'b001; m_addr[31:0] = 32'h0010_0004;
      #1 chk("t1_gnt", m_gnt, 3'b001);
      chk("t1_sreq", s_req, 3'b010);
      chk("t1_saddr", s_addr[63:32], 32'h0010_0004);
      push_exp(0, 32'hCAFE, 1'b0);
      step(); m_req = '0;
      #1 chk("t1_wait_sreq", s_req, 3'b000);
      step(); s_rvalid = 3'b010; s_rdata[63:32] = 32'hCAFE;
      #1 chk("t1_rvalid", m_rvalid, 3'b001);
      step(); s_rvalid = '0;
      #1 chk("t1_rvalid_off", m_rvalid, 3'b000);

      // 2: all masters hammer slave 0, round robin with wrap
      for (int i = 0; i < 4; i++) begin
         step(); s_rvalid = '0;
         m_req = 3'b111;
         m_addr = {32'h8, 32'h4, 32'h0};
         #1 chk($sformatf("t2_gnt%0d", i), m_gnt, 3'b001 << ord[i]);
         push_exp(ord[i], rr_dat[i], 1'b0);
         step(); s_rvalid = 3'b001; s_rdata[31:0] = rr_dat[i];
         #1 chk($sformatf("t2_hold%0d", i), m_gnt, 3'b000);
      end
      step(); m_req = '0; s_rvalid = '0;
      #1 chk("t2_idle_gnt", m_gnt, 3'b000);

      // 3: unmapped read goes to the error responder
      step(); m_req = 3'b010; m_addr[63:32] = 32'h8000_0000;
      #1 chk("t3_gnt", m_gnt, 3'b010);
      chk("t3_sreq", s_req, 3'b000);
      push_exp(1, 32'hBADA_CCE5, 1'b1);
      step(); m_req = '0;
      #1 chk("t3_rvalid", m_rvalid, 3'b010);
      chk("t3_err", m_err, 3'b010);
      chk("t3_sreq2", s_req, 3'b000);
      step();
      #1 chk("t3_rvalid_off", m_rvalid, 3'b000);

      // 4: parallel accesses to slave 0 (write) and slave 2 (read)
      step(); m_req = 3'b011;
      m_addr[31:0] = 32'h10; m_we = 3'b001; m_be[3:0] = 4'h3; m_wdata[31:0] = 32'hA5A5;
      m_addr[63:32] = 32'h1A10_0010;
      #1 chk("t4_gnt", m_gnt, 3'b011);
      chk("t4_sreq", s_req, 3'b101);
      chk("t4_swe", s_we, 3'b001);
      chk("t4_sbe", s_be[3:0], 4'h3);
      chk("t4_swdata", s_wdata[31:0], 32'hA5A5);
      chk("t4_saddr2", s_addr[95:64], 32'h1A10_0010);
      push_exp(1, 32'h2222, 1'b0);
      push_exp(0, 32'h1111, 1'b0);
      step(); m_req = '0; m_we = '0; s_rvalid = 3'b100; s_rdata[95:64] = 32'h2222;
      #1 chk("t4_rv_m1", m_rvalid, 3'b010);
      step(); s_rvalid = 3'b001; s_rdata[31:0] = 32'h1111;
      #1 chk("t4_rv_m0", m_rvalid, 3'b001);
      step(); s_rvalid = '0;

      // 6: M2 holds req while pending
      step(); m_req = 3'b100; m_addr[95:64] = 32'h1A10_0020;
      #1 chk("t6_gnt", m_gnt, 3'b100);
      push_exp(2, 32'h1234, 1'b0);
      step();
      #1 chk("t6_pend_gnt", m_gnt, 3'b000);
      chk("t6_pend_sreq", s_req, 3'b000);
      step(); s_rvalid = 3'b100; s_rdata[95:64] = 32'h1234;
      #1 chk("t6_rv_gnt", m_gnt, 3'b000);
      chk("t6_rv", m_rvalid, 3'b100);
      step(); s_rvalid = '0;
      #1 chk("t6_regnt", m_gnt, 3'b100);
      chk("t6_resreq", s_req, 3'b100);
      push_exp(2, 32'h5678, 1'b0);
      step(); m_req = '0;
      step(); s_rvalid = 3'b100; s_rdata[95:64] = 32'h5678;
      #1 chk("t6_rv2", m_rvalid, 3'b100);
      step(); s_rvalid = '0;

      // 5: reset mid-transaction, late response dropped
      step(); m_req = 3'b001; m_addr[31:0] = 32'h20;
      #1 chk("t5_gnt", m_gnt, 3'b001);
      step(); m_req = '0; rst = 1'b1;
      #1 chk("t5_rst_sreq", s_req, 3'b000);
      chk("t5_rst_gnt", m_gnt, 3'b000);
      chk("t5_rst_rvalid", m_rvalid, 3'b000);
      chk("t5_rst_err", m_err, 3'b000);
      chk("t5_rst_rdata", m_rdata, 96'h0);
      chk("t5_rst_payload", {s_we, s_be, s_wdata[31:0]}, 47'h0);
      step(); rst = 1'b0; s_rvalid = 3'b001; s_rdata[31:0] = 32'hDEAD;
      #1 chk("t5_late_drop", m_rvalid, 3'b000);
      step(); s_rvalid = '0; m_req = 3'b001; m_addr[31:0] = 32'h24;
      #1 chk("t5_new_gnt", m_gnt, 3'b001);
      push_exp(0, 32'h4444, 1'b0);
      step(); m_req = '0;
      step(); s_rvalid = 3'b001; s_rdata[31:0] = 32'h4444;
      #1 chk("t5_new_rv", m_rvalid, 3'b001);
      step(); s_rvalid = '0;

      step();
      step();
      #3 chk("queue_empty", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
